// File: rtl/datapath_pkg.sv
// datapath_pkg: shared constants and types for the 16-bit single-cycle datapath.
//   - alu_op_e      : ALU operation encoding driven by the control unit
//   - *_SEL         : select encodings for regDst / memToReg / jump / aluSrc
//   - *_LSB / *_MSB : instruction field bit positions
//   - sext6         : sign-extend the 6-bit immediate to WIDTH bits
package datapath_pkg;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam logic [2:0]  REG_LINK = 3'd7;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  // regDst
  localparam logic [1:0] REGDST_RT   = 2'b00;
  localparam logic [1:0] REGDST_RD   = 2'b01;
  localparam logic [1:0] REGDST_LINK = 2'b10;

  // memToReg
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC2 = 2'b10;

  // jump
  localparam logic [1:0] JMP_SEQ = 2'b00;
  localparam logic [1:0] JMP_ABS = 2'b01;
  localparam logic [1:0] JMP_REG = 2'b10;

  // aluSrc
  localparam logic [1:0] BSRC_RT   = 2'b00;
  localparam logic [1:0] BSRC_SEXT = 2'b01;
  localparam logic [1:0] BSRC_ZEXT = 2'b10;
  localparam logic [1:0] BSRC_HI   = 2'b11;

  // Instruction field positions
  localparam int unsigned RS_LSB   = 9;
  localparam int unsigned RT_LSB   = 6;
  localparam int unsigned RD_LSB   = 3;
  localparam int unsigned IMM_MSB  = 5;
  localparam int unsigned ADDR_MSB = 11;

  function automatic logic [WIDTH-1:0] sext6(input logic [5:0] imm);
    return {{(WIDTH-6){imm[5]}}, imm};
  endfunction

endpackage

// File: rtl/dp_regfile.sv
// dp_regfile: 8 x 16-bit register file, two combinational read ports, one
// synchronous write port. r0 always reads zero and ignores writes.
// Synchronous active-low reset clears every register.
// Optional macro REGFILE_BYPASS_EN: a read matching the active write index
// (non-zero, reset released) returns wdata_i combinationally.
//   clk        in   clock, rising edge
//   reset      in   synchronous reset, active low
//   we_i       in   write enable
//   waddr_i    in   write index
//   wdata_i    in   write data
//   raddr_a_i  in   read port A index     rdata_a_o  out  read port A data
//   raddr_b_i  in   read port B index     rdata_b_o  out  read port B data
module dp_regfile
  import datapath_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [2:0]       waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [2:0]       raddr_a_i,
  input  logic [2:0]       raddr_b_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic [WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
`ifdef REGFILE_BYPASS_EN
    if (reset && we_i && (waddr_i != '0)) begin
      if (waddr_i == raddr_a_i) rdata_a_o = wdata_i;
      if (waddr_i == raddr_b_i) rdata_b_o = wdata_i;
    end
`endif
  end

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: 16-bit single-cycle MIPS-style datapath (PC, register file,
// ALU, immediate extension, next-PC and writeback muxes). Instruction/data
// memories and control are external. Optional macro REGFILE_BYPASS_EN
// enables register-file write-through (see dp_regfile).
//   clk, reset       clock / synchronous active-low reset
//   regWrite         register write enable
//   regDst[1:0]      dest: 00 rt, 01 rd, 10 r7, 11 rt
//   memToReg[1:0]    writeback: 00 ALU, 01 readData, 10 pc+2, 11 ALU
//   jump[1:0]        00 seq/branch, 01 absolute, 10 jump-register, 11 seq/branch
//   aluSrc[1:0]      B: 00 rt, 01 sext imm6, 10 zext imm6, 11 {imm6,10'b0}
//   pcSrc            take branch target when not jumping
//   aluCtrl[2:0]     ALU operation (alu_op_e)
//   instruction      current instruction
//   readData         data memory read data
//   aluResult        ALU output / data memory address
//   memWriteData     rt value (store data)
//   pc               current PC
//   zero             aluResult == 0
module cpu_datapath
  import datapath_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        regWrite,
  input  logic [1:0]  regDst,
  input  logic [1:0]  memToReg,
  input  logic [1:0]  jump,
  input  logic [1:0]  aluSrc,
  input  logic        pcSrc,
  input  logic [2:0]  aluCtrl,
  input  logic [15:0] instruction,
  input  logic [15:0] readData,
  output logic [15:0] aluResult,
  output logic [15:0] memWriteData,
  output logic [15:0] pc,
  output logic        zero
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [2:0]       rs_idx, rt_idx, rd_idx, dest_idx;
  logic [5:0]       imm6;
  logic [11:0]      addr12;
  logic [3:0]       unused_opcode;
  logic [WIDTH-1:0] rs_val, rt_val, b_val, alu_res, wb_val;
  logic [WIDTH-1:0] pc_plus2, branch_tgt, jump_tgt;
  alu_op_e          alu_op;

  assign rs_idx        = instruction[RS_LSB +: 3];
  assign rt_idx        = instruction[RT_LSB +: 3];
  assign rd_idx        = instruction[RD_LSB +: 3];
  assign imm6          = instruction[IMM_MSB:0];
  assign addr12        = instruction[ADDR_MSB:0];
  assign unused_opcode = instruction[15:12];

  always_comb begin
    unique case (regDst)
      REGDST_RD:   dest_idx = rd_idx;
      REGDST_LINK: dest_idx = REG_LINK;
      default:     dest_idx = rt_idx;
    endcase
  end

  dp_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_i      (regWrite),
    .waddr_i   (dest_idx),
    .wdata_i   (wb_val),
    .raddr_a_i (rs_idx),
    .raddr_b_i (rt_idx),
    .rdata_a_o (rs_val),
    .rdata_b_o (rt_val)
  );

  always_comb begin
    unique case (aluSrc)
      BSRC_SEXT: b_val = sext6(imm6);
      BSRC_ZEXT: b_val = {{(WIDTH-6){1'b0}}, imm6};
      BSRC_HI:   b_val = {imm6, 10'b0};
      default:   b_val = rt_val;
    endcase
  end

  assign alu_op = alu_op_e'(aluCtrl);

  always_comb begin
    unique case (alu_op)
      ALU_AND: alu_res = rs_val & b_val;
      ALU_OR:  alu_res = rs_val | b_val;
      ALU_ADD: alu_res = rs_val + b_val;
      ALU_XOR: alu_res = rs_val ^ b_val;
      ALU_NOR: alu_res = ~(rs_val | b_val);
      ALU_SLL: alu_res = rs_val << b_val[3:0];
      ALU_SUB: alu_res = rs_val - b_val;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(rs_val) < $signed(b_val))};
      default: alu_res = '0;
    endcase
  end

  assign pc_plus2   = pc_q + 16'd2;
  assign branch_tgt = pc_plus2 + {sext6(imm6)[WIDTH-2:0], 1'b0};
  assign jump_tgt   = {pc_plus2[15:13], addr12, 1'b0};

  always_comb begin
    unique case (memToReg)
      WB_MEM:  wb_val = readData;
      WB_PC2:  wb_val = pc_plus2;
      default: wb_val = alu_res;
    endcase
  end

  always_comb begin
    unique case (jump)
      JMP_ABS: pc_d = jump_tgt;
      JMP_REG: pc_d = {rs_val[WIDTH-1:1], 1'b0};
      default: pc_d = pcSrc ? branch_tgt : pc_plus2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign aluResult    = alu_res;
  assign memWriteData = rt_val;
  assign pc           = pc_q;
  assign zero         = (alu_res == '0);

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed steps from the test plan,
// then randomized control/instruction streams checked against an
// arithmetic reference model of the architectural state.
module tb_cpu_datapath;

  logic        clk;
  logic        reset;
  logic        regWrite;
  logic [1:0]  regDst, memToReg, jump, aluSrc;
  logic        pcSrc;
  logic [2:0]  aluCtrl;
  logic [15:0] instruction, readData;
  logic [15:0] aluResult, memWriteData, pc;
  logic        zero;

  int errors = 0;
  int checks = 0;

  // Reference architectural state
  int mregs [8];
  int mpc;

  cpu_datapath dut (
    .clk          (clk),
    .reset        (reset),
    .regWrite     (regWrite),
    .regDst       (regDst),
    .memToReg     (memToReg),
    .jump         (jump),
    .aluSrc       (aluSrc),
    .pcSrc        (pcSrc),
    .aluCtrl      (aluCtrl),
    .instruction  (instruction),
    .readData     (readData),
    .aluResult    (aluResult),
    .memWriteData (memWriteData),
    .pc           (pc),
    .zero         (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sext(input int v6);
    return (v6 >= 32) ? (v6 + 65536 - 64) : v6;
  endfunction

  function automatic int to_signed(input int v);
    return (v >= 32768) ? (v - 65536) : v;
  endfunction

  task automatic drive(input logic rw, input logic [1:0] rdst, input logic [1:0] m2r,
                       input logic [1:0] jmp, input logic [1:0] asrc, input logic ps,
                       input logic [2:0] ac, input logic [15:0] ins, input logic [15:0] rdat);
    regWrite = rw; regDst = rdst; memToReg = m2r; jump = jmp; aluSrc = asrc;
    pcSrc = ps; aluCtrl = ac; instruction = ins; readData = rdat;
  endtask

  // Compare all outputs against the model, clock once, advance the model.
  task automatic tick(input string tag);
    int ins, rsi, rti, rdi, imm, addr, dest, a, b, rsv, rtv, alu, wb, p2, npc;
    #1;
    ins  = int'(instruction);
    rsi  = (ins / 512) % 8;
    rti  = (ins / 64) % 8;
    rdi  = (ins / 8) % 8;
    imm  = ins % 64;
    addr = ins % 4096;
    dest = (regDst == 2'd1) ? rdi : (regDst == 2'd2) ? 7 : rti;
    p2   = (mpc + 2) % 65536;
    rsv  = (rsi == 0) ? 0 : mregs[rsi];
    rtv  = (rti == 0) ? 0 : mregs[rti];
`ifdef REGFILE_BYPASS_EN
    if (reset && regWrite && dest != 0 && (memToReg == 2'd1 || memToReg == 2'd2)) begin
      wb = (memToReg == 2'd1) ? int'(readData) : p2;
      if (rsi == dest) rsv = wb;
      if (rti == dest) rtv = wb;
    end
`endif
    a = rsv;
    case (aluSrc)
      2'd0: b = rtv;
      2'd1: b = sext(imm);
      2'd2: b = imm;
      default: b = imm * 1024;
    endcase
    case (aluCtrl)
      3'd0: alu = a & b;
      3'd1: alu = a | b;
      3'd2: alu = (a + b) % 65536;
      3'd3: alu = a ^ b;
      3'd4: alu = 65535 - (a | b);
      3'd5: alu = (a * (1 << (b % 16))) % 65536;
      3'd6: alu = (a - b + 65536) % 65536;
      default: alu = (to_signed(a) < to_signed(b)) ? 1 : 0;
    endcase
    wb = (memToReg == 2'd1) ? int'(readData) : (memToReg == 2'd2) ? p2 : alu;
    if (jump == 2'd1)      npc = (p2 / 8192) * 8192 + addr * 2;
    else if (jump == 2'd2) npc = rsv - (rsv % 2);
    else if (pcSrc)        npc = (p2 + sext(imm) * 2) % 65536;
    else                   npc = p2;

    chk({tag, ".alu"},  aluResult,    16'(alu));
    chk({tag, ".zero"}, {15'd0, zero}, (alu == 0) ? 16'd1 : 16'd0);
    chk({tag, ".mwd"},  memWriteData, 16'(rtv));
    chk({tag, ".pc"},   pc,           16'(mpc));

    @(posedge clk);
    if (!reset) begin
      mpc = 0;
      foreach (mregs[i]) mregs[i] = 0;
    end else begin
      mpc = npc;
      if (regWrite && dest != 0) mregs[dest] = wb;
    end
    #1;
  endtask

  int bpc;

  initial begin
    foreach (mregs[i]) mregs[i] = 0;
    mpc = 0;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst.pc", pc, 16'h0000);
    chk("rst.alu", aluResult, 16'h0000);
    chk("rst.zero", {15'd0, zero}, 16'h0001);
    chk("rst.mwd", memWriteData, 16'h0000);
    tick("rst");
    reset = 1'b1;

    // addi r1 = r0 + 7
    drive(1, 2'd0, 2'd0, 2'd0, 2'd1, 0, 3'd2, 16'ha047, 16'h0000);
    #1;
    chk("addi.alu", aluResult, 16'h0007);
    chk("addi.zero", {15'd0, zero}, 16'h0000);
    tick("addi");
    chk("addi.pc_next", pc, 16'h0002);

    // rs=1, rt=1 read back
    drive(0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 16'h0240, 16'h0000);
    #1;
    chk("rd_r1.alu", aluResult, 16'h0007);
    chk("rd_r1.mwd", memWriteData, 16'h0007);
    tick("rd_r1");

    // load BEEF into r2, then read it
    drive(1, 2'd0, 2'd1, 2'd0, 2'd1, 0, 3'd2, 16'h0080, 16'hBEEF);
    tick("load");
    drive(0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 3'd2, 16'h0400, 16'h0000);
    #1;
    chk("load.rd", aluResult, 16'hBEEF);
    tick("load_rd");

    // r1 = r2 = 5, then branch with imm -1 back onto itself
    drive(1, 2'd0, 2'd0, 2'd0, 2'd1, 0, 3'd2, 16'h0045, 16'h0000);
    tick("set_r1");
    drive(1, 2'd0, 2'd0, 2'd0, 2'd1, 0, 3'd2, 16'h0085, 16'h0000);
    tick("set_r2");
    bpc = mpc;
    drive(0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 3'd6, 16'h02BF, 16'h0000);
    #1;
    chk("beq.zero", {15'd0, zero}, 16'h0001);
    tick("beq");
    chk("beq.self", pc, 16'(bpc));
    drive(0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 3'd6, 16'h02BF, 16'h0000);
    tick("bnt");
    chk("bnt.pc", pc, 16'(bpc + 2));
    bpc = mpc;
    drive(0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 3'd6, 16'h0282, 16'h0000);
    tick("bfwd");
    chk("bfwd.pc", pc, 16'(bpc + 6));

    // jump to 0010, jal 123, jr r7
    drive(0, 2'd0, 2'd0, 2'd1, 2'd0, 0, 3'd0, 16'h0008, 16'h0000);
    tick("j10");
    chk("j10.pc", pc, 16'h0010);
    drive(1, 2'd2, 2'd2, 2'd1, 2'd0, 0, 3'd0, 16'h0123, 16'h0000);
    tick("jal");
    chk("jal.pc", pc, 16'h0246);
    drive(0, 2'd0, 2'd0, 2'd2, 2'd0, 0, 3'd2, 16'h0E00, 16'h0000);
    #1;
    chk("jal.r7", aluResult, 16'h0012);
    tick("jr");
    chk("jr.pc", pc, 16'h0012);

    // r0 write discarded
    drive(1, 2'd0, 2'd0, 2'd0, 2'd1, 0, 3'd2, 16'h003F, 16'h0000);
    #1;
    chk("r0w.alu", aluResult, 16'hFFFF);
    tick("r0w");
    drive(0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 3'd2, 16'h0000, 16'h0000);
    #1;
    chk("r0.rd", aluResult, 16'h0000);
    chk("r0.zero", {15'd0, zero}, 16'h0001);
    tick("r0");

    // PC wrap FFFE -> 0000
    drive(1, 2'd0, 2'd1, 2'd0, 2'd1, 0, 3'd2, 16'h00C0, 16'hFFFE);
    tick("ld_r3");
    drive(0, 2'd0, 2'd0, 2'd2, 2'd0, 0, 3'd0, 16'h0600, 16'h0000);
    tick("jr_r3");
    chk("wrap.pre", pc, 16'hFFFE);
    drive(0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 3'd0, 16'h0000, 16'h0000);
    tick("wrap");
    chk("wrap.pc", pc, 16'h0000);

    // SLT signed: 8000 < 0001
    drive(1, 2'd0, 2'd1, 2'd0, 2'd1, 0, 3'd2, 16'h0100, 16'h8000);
    tick("ld_r4");
    drive(0, 2'd0, 2'd0, 2'd0, 2'd1, 0, 3'd7, 16'h0801, 16'h0000);
    #1;
    chk("slt.alu", aluResult, 16'h0001);
    tick("slt");

    // Mid-program reset clears PC and registers
    reset = 1'b0;
    tick("mid_rst");
    reset = 1'b1;
    drive(0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 3'd2, 16'h0800, 16'h0000);
    #1;
    chk("mid_rst.pc", pc, 16'h0000);
    chk("mid_rst.r4", aluResult, 16'h0000);
    tick("post_rst");

    // Randomized stream
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ins;
      logic [1:0]  rdst, m2r;
      logic        rw;
      int          dst;
      ins  = 16'($urandom);
      rdst = 2'($urandom);
      m2r  = 2'($urandom);
      rw   = 1'($urandom);
      dst  = (rdst == 2'd1) ? int'(ins[5:3]) : (rdst == 2'd2) ? 7 : int'(ins[8:6]);
      // Keep ALU writeback from feeding back into its own operand read.
      if (rw && (m2r == 2'd0 || m2r == 2'd3) &&
          (dst == int'(ins[11:9]) || dst == int'(ins[8:6])))
        m2r = 2'd1;
      reset = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      drive(rw, rdst, m2r, 2'($urandom), 2'($urandom), 1'($urandom),
            3'($urandom), ins, 16'($urandom));
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
